// File: rtl/stc_intc_pkg.sv
// Shared constants for the system-timer interrupt controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package stc_intc_pkg;

  // Number of sources: timer_int[3:0] plus wdg_out_int at bit 4.
  localparam int NSRC_DEF = 5;

  // Width of each per-source saturating event counter.
  localparam int CNT_W = 8;

  // Register word addresses (paddr[11:2]).
  localparam logic [9:0] ADDR_CTRL   = 10'h000;
  localparam logic [9:0] ADDR_MASK   = 10'h001;
  localparam logic [9:0] ADDR_PEND   = 10'h002;
  localparam logic [9:0] ADDR_EOI    = 10'h003;
  localparam logic [9:0] ADDR_STATUS = 10'h004;
  localparam logic [9:0] ADDR_CNT0   = 10'h008;

  // Request/service state encoding, visible in STATUS[1:0].
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/stc_intc_src.sv
// Per-source slice: input edge detect, pending bit and saturating event counter.
// Latency: src high in cycle t -> pending visible in cycle t+2 (edge and level alike).
// Backpressure: none; counter saturates at all-ones instead of wrapping.
module stc_intc_src
  import stc_intc_pkg::*;
(
  input  logic             pclk,
  input  logic             preset,
  input  logic             src,
  input  logic             mode,     // 1 = edge, 0 = level
  input  logic             w1c,      // software clear of the pending bit
  input  logic             ack_clr,  // clear on core acknowledge
  input  logic             cnt_clr,  // software clear of the counter
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);

  logic src_q;
  logic ev;
  logic ev_q;

  // Rising edge seen on the raw input against its one-cycle-old copy.
  assign ev = src & ~src_q;

  // Input history; the event is registered once more so edge-mode pending
  // lands on the same cycle as level-mode pending (which follows src_q).
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      src_q <= 1'b0;
      ev_q  <= 1'b0;
    end else begin
      src_q <= src;
      ev_q  <= ev;
    end
  end

  // Pending: a new edge beats any clear in the same cycle; level sources
  // simply mirror src_q so a clear cannot stick.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pend <= 1'b0;
    end else if (mode) begin
      if (ev_q)
        pend <= 1'b1;
      else if (w1c || ack_clr)
        pend <= 1'b0;
    end else begin
      pend <= src_q;
    end
  end

  // Event counter counts every edge in either mode; a clear write wins.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (ev && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stc_intc.sv
// Interrupt controller for the system timer: APB registers, per-source pending, fixed-priority request FSM.
// Latency: src_in edge in cycle t -> pending at t+2 -> irq_req at t+3; APB read data one cycle after setup.
// Backpressure: none; pready is tied high and irq_req holds until ack or the request is withdrawn.
module stc_intc
  import stc_intc_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [11:2]     paddr,
  input  logic [31:0]     pwdata,
  output logic [31:0]     prdata,
  output logic            pready,
  input  logic [NSRC-1:0] src_in,
  output logic            irq_req,
  output logic [2:0]      irq_id,
  input  logic            irq_ack
);

  logic            wr;
  logic            rd;
  logic            gen;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] active;
  logic [2:0]      sel;
  logic [1:0]      state;
  logic [31:0]     rdata;
  logic            eoi_wr;
  logic            gen_off_wr;
  logic [CNT_W-1:0] cnt [NSRC];
  logic            unused_pwdata;

  assign pready = 1'b1;

  // Registers are accessed in the APB setup phase.
  assign wr = psel & pwrite & ~penable;
  assign rd = psel & ~pwrite & ~penable;

  assign eoi_wr     = wr && (paddr == ADDR_EOI);
  assign gen_off_wr = wr && (paddr == ADDR_CTRL) && !pwdata[0];

  assign unused_pwdata = ^pwdata[31:4+NSRC];

  // One slice per source.
  for (genvar n = 0; n < NSRC; n++) begin : g_src
    stc_intc_src u_src (
      .pclk    (pclk),
      .preset  (preset),
      .src     (src_in[n]),
      .mode    (mode[n]),
      .w1c     (wr && (paddr == ADDR_PEND) && pwdata[n]),
      .ack_clr ((state == ST_REQ) && irq_ack && (irq_id == 3'(n))),
      .cnt_clr (wr && (paddr == (ADDR_CNT0 + 10'(n)))),
      .pend    (pend[n]),
      .cnt     (cnt[n])
    );
  end

  // CTRL and MASK storage.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      gen  <= 1'b0;
      mode <= '0;
      mask <= '0;
    end else if (wr) begin
      if (paddr == ADDR_CTRL) begin
        gen  <= pwdata[0];
        mode <= pwdata[4 +: NSRC];
      end
      if (paddr == ADDR_MASK)
        mask <= pwdata[NSRC-1:0];
    end
  end

  assign active = pend & mask & {NSRC{gen}};

  // Lowest set index of active wins.
  always_comb begin
    sel = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i])
        sel = 3'(i);
    end
  end

  // Request FSM; disabling GEN forces idle but leaves pending untouched.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state  <= ST_IDLE;
      irq_id <= 3'd0;
    end else if (gen_off_wr) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (active != '0) begin
            state  <= ST_REQ;
            irq_id <= sel;
          end
        end
        ST_REQ: begin
          if (irq_ack)
            state <= ST_SERVICE;
          else if (!active[irq_id])
            state <= ST_IDLE;
        end
        ST_SERVICE: begin
          if (eoi_wr)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq_req = (state == ST_REQ);

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (paddr)
      ADDR_CTRL: begin
        rdata[0]           = gen;
        rdata[4 +: NSRC]   = mode;
      end
      ADDR_MASK:   rdata[NSRC-1:0] = mask;
      ADDR_PEND:   rdata[NSRC-1:0] = pend;
      ADDR_STATUS: begin
        rdata[1:0] = state;
        rdata[6:4] = irq_id;
      end
      default: begin
        for (int i = 0; i < NSRC; i++) begin
          if (paddr == (ADDR_CNT0 + 10'(i)))
            rdata[CNT_W-1:0] = cnt[i];
        end
      end
    endcase
  end

  // Read data is captured in the setup phase and held for the access phase.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)
      prdata <= '0;
    else if (rd)
      prdata <= rdata;
  end

endmodule

// File: tb/tb_stc_intc.sv
// Directed bench for stc_intc with a scoreboard of expected read data and request ids.
// Latency: checks the src edge -> irq_req three-cycle path explicitly.
// Backpressure: none exercised; pready is expected high throughout.
module tb_stc_intc;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:2] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic [4:0]  src_in;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;

  int          tests;
  int          fails;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] rd_data;

  stc_intc #(.NSRC(5)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .src_in  (src_in),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .irq_ack (irq_ack)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [9:0] addr, input logic [31:0] data);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] addr, output logic [31:0] data);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
    tick();
    data = prdata;
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  // Expected value queued before the read is issued, compared when data returns.
  task automatic read_chk(input logic [9:0] addr, input logic [31:0] msk,
                          input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    apb_read(addr, rd_data);
    check(tag_q.pop_front(), rd_data & msk, exp_q.pop_front());
  endtask

  // Expected id queued, then wait (bounded) for the request to appear.
  task automatic expect_irq(input logic [2:0] exp_id, input string tag);
    int n;
    exp_q.push_back({29'd0, exp_id});
    n = 0;
    while (irq_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'd0, irq_req}, 32'd1);
    check({tag, "_id"}, {29'd0, irq_id}, exp_q.pop_front());
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; src_in = '0; irq_ack = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_irq_req", {31'd0, irq_req}, 32'd0);
    check("rst_irq_id", {29'd0, irq_id}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd1);
    preset = 1'b0;
    tick();
    read_chk(10'h000, 32'hFFFF_FFFF, 32'h0, "rst_ctrl");
    read_chk(10'h001, 32'hFFFF_FFFF, 32'h0, "rst_mask");
    read_chk(10'h004, 32'hFFFF_FFFF, 32'h0, "rst_status");
    read_chk(10'h00B, 32'hFFFF_FFFF, 32'h0, "rst_cnt3");
    read_chk(10'h020, 32'hFFFF_FFFF, 32'h0, "unmapped");

    // Edge request with latency check
    apb_write(10'h000, 32'h1F1);
    apb_write(10'h001, 32'h1F);
    read_chk(10'h000, 32'hFFFF_FFFF, 32'h1F1, "ctrl_rb");
    src_in = 5'b00100;
    exp_q.push_back(32'd2);
    tick();
    src_in = 5'b00000;
    check("lat_t1", {31'd0, irq_req}, 32'd0);
    tick();
    check("lat_t2", {31'd0, irq_req}, 32'd0);
    tick();
    check("lat_t3_req", {31'd0, irq_req}, 32'd1);
    check("lat_t3_id", {29'd0, irq_id}, exp_q.pop_front());
    ack();
    check("ack_req_low", {31'd0, irq_req}, 32'd0);
    read_chk(10'h002, 32'hFFFF_FFFF, 32'h0, "edge_pend_clr");
    read_chk(10'h004, 32'hFFFF_FFFF, 32'h22, "edge_status_svc");
    apb_write(10'h003, 32'h0);
    read_chk(10'h004, 32'h3, 32'h0, "edge_status_idle");
    read_chk(10'h00A, 32'hFFFF_FFFF, 32'h1, "edge_cnt2");

    // Priority: sources 4 and 1 together
    src_in = 5'b10010;
    tick();
    src_in = 5'b00000;
    expect_irq(3'd1, "prio_first");
    ack();
    apb_write(10'h003, 32'h0);
    expect_irq(3'd4, "prio_second");
    ack();
    apb_write(10'h003, 32'h0);
    read_chk(10'h002, 32'hFFFF_FFFF, 32'h0, "prio_pend");

    // Level mode on source 0
    apb_write(10'h000, 32'h1E1);
    src_in[0] = 1'b1;
    expect_irq(3'd0, "lvl_first");
    ack();
    tick();
    read_chk(10'h004, 32'hFFFF_FFFF, 32'h02, "lvl_status_svc");
    apb_write(10'h003, 32'h0);
    expect_irq(3'd0, "lvl_rearm");
    ack();
    src_in[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    apb_write(10'h003, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("lvl_no_rereq", {31'd0, irq_req}, 32'd0);
    read_chk(10'h004, 32'h3, 32'h0, "lvl_status_idle");

    // Counter saturation and clear-wins
    apb_write(10'h000, 32'h1F1);
    apb_write(10'h001, 32'h17);
    for (int i = 0; i < 200; i++) begin
      src_in[3] = 1'b1; tick();
      src_in[3] = 1'b0; tick();
    end
    read_chk(10'h00B, 32'hFFFF_FFFF, 32'd200, "cnt3_200");
    for (int i = 0; i < 100; i++) begin
      src_in[3] = 1'b1; tick();
      src_in[3] = 1'b0; tick();
    end
    read_chk(10'h00B, 32'hFFFF_FFFF, 32'hFF, "cnt3_sat");
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 10'h00B; pwdata = '0;
    src_in[3] = 1'b1;
    tick();
    penable = 1'b1; src_in[3] = 1'b0;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    read_chk(10'h00B, 32'hFFFF_FFFF, 32'h0, "cnt3_clr_sat");
    for (int i = 0; i < 3; i++) begin
      src_in[3] = 1'b1; tick();
      src_in[3] = 1'b0; tick();
    end
    read_chk(10'h00B, 32'hFFFF_FFFF, 32'd3, "cnt3_three");
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 10'h00B; pwdata = '0;
    src_in[3] = 1'b1;
    tick();
    penable = 1'b1; src_in[3] = 1'b0;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    read_chk(10'h00B, 32'hFFFF_FFFF, 32'h0, "cnt3_clr_wins");

    // Set vs W1C on source 0 (masked so no request fires)
    apb_write(10'h001, 32'h16);
    apb_write(10'h002, 32'h1F);
    read_chk(10'h002, 32'hFFFF_FFFF, 32'h0, "w1c_all");
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 10'h002; pwdata = 32'h1;
    src_in[0] = 1'b1;
    tick();
    penable = 1'b1; src_in[0] = 1'b0;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    read_chk(10'h002, 32'h1, 32'h1, "set_vs_w1c_a");
    apb_write(10'h002, 32'h1);
    read_chk(10'h002, 32'h1, 32'h0, "w1c_edge");
    src_in[0] = 1'b1;
    tick();
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 10'h002; pwdata = 32'h1;
    src_in[0] = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    read_chk(10'h002, 32'h1, 32'h1, "set_vs_w1c_b");

    // GEN=0 drops to idle but keeps pending
    apb_write(10'h001, 32'h1F);
    expect_irq(3'd0, "gen_pre");
    apb_write(10'h000, 32'h1F0);
    check("gen_off_req", {31'd0, irq_req}, 32'd0);
    read_chk(10'h004, 32'h3, 32'h0, "gen_off_state");
    read_chk(10'h002, 32'h1, 32'h1, "gen_off_pend");
    apb_write(10'h000, 32'h1F1);
    expect_irq(3'd0, "gen_on");

    // Reset while requesting
    preset = 1'b1;
    #1;
    check("mrst_req", {31'd0, irq_req}, 32'd0);
    tick();
    preset = 1'b0;
    tick();
    read_chk(10'h004, 32'hFFFF_FFFF, 32'h0, "mrst_status");
    read_chk(10'h001, 32'hFFFF_FFFF, 32'h0, "mrst_mask");
    read_chk(10'h002, 32'hFFFF_FFFF, 32'h0, "mrst_pend");
    for (int i = 0; i < 5; i++) tick();
    check("mrst_no_req", {31'd0, irq_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
